// File: rtl/cpu_types.sv
// Shared core types: reservation-station tags, the CDB broadcast record and
// the CDB requester numbering.
package cpu_types;

  localparam int TAG_W      = 5;
  localparam int CDB_DATA_W = 32;

  typedef logic [TAG_W-1:0] RS_tag_type;

  // Tag value reserved to mean "no result".
  localparam RS_tag_type INVALID = '0;

  typedef struct packed {
    RS_tag_type            tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_t;

  localparam cdb_t CDB_IDLE = '{tag: INVALID, data: '0};

  localparam int CDB_NUM_REQ = 4;
  localparam int CDB_LOAD1   = 0;
  localparam int CDB_LOAD2   = 1;
  localparam int CDB_ALU1    = 2;
  localparam int CDB_ALU2    = 3;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side handshakes and the CDB broadcast of the result arbiter.
interface cdb_arbiter_if import cpu_types::*; #(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int DATA_W  = CDB_DATA_W
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic                           flush;
  logic [NUM_REQ-1:0]             req_valid;
  RS_tag_type [NUM_REQ-1:0]       req_tag;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;
  cdb_t                           cdb_out;
  logic                           cdb_valid;
  logic [IDX_W-1:0]               grant_idx;

  modport master (
    output flush, req_valid, req_tag, req_data,
    input  req_ready, cdb_out, cdb_valid, grant_idx
  );

  modport slave (
    input  flush, req_valid, req_tag, req_data,
    output req_ready, cdb_out, cdb_valid, grant_idx
  );

endinterface

// File: rtl/cdb_req_fifo.sv
// Small per-producer result FIFO; pointers carry one extra wrap bit so full
// and empty are distinguishable without a separate counter.
module cdb_req_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] entry,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PTR_W  = IDX_W + 1;
  localparam int SLOT_W = (IDX_W > 0) ? IDX_W : 1;
  localparam logic [PTR_W-1:0] FULL_XOR = PTR_W'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [SLOT_W-1:0] wr_slot, rd_slot;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  if (IDX_W > 0) begin : g_slot
    assign wr_slot = wr_ptr_q[SLOT_W-1:0];
    assign rd_slot = rd_ptr_q[SLOT_W-1:0];
  end else begin : g_single
    assign wr_slot = '0;
    assign rd_slot = '0;
  end

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = ((wr_ptr_q ^ rd_ptr_q) == FULL_XOR);
  assign head    = mem_q[rd_slot];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which slots hold live entries.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_slot] <= entry;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin scheduler of the common data bus: one bounded FIFO per result
// producer, at most one pop per cycle, registered broadcast.
module cdb_arbiter import cpu_types::*; #(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int DEPTH   = 2,
  parameter int DATA_W  = CDB_DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  cdb_arbiter_if.slave  bus
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int TAG_W_L = $bits(RS_tag_type);
  localparam int ENTRY_W = TAG_W_L + DATA_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0] push, pop, empty, full;
  logic [ENTRY_W-1:0] head [NUM_REQ];
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   winner, cand;
  logic               found;
  cdb_t               cdb_q, cdb_d;
  logic               cdb_valid_q, cdb_valid_d;

  // Ready looks at the pre-pop fill level, so a full FIFO never accepts in the cycle it drains.
  assign bus.req_ready = ~full & {NUM_REQ{~bus.flush}};

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign push[i] = bus.req_valid[i] && bus.req_ready[i] && (bus.req_tag[i] != INVALID);
    assign pop[i]  = found && !bus.flush && (winner == IDX_W'(i));

    cdb_req_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (ENTRY_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (bus.flush),
      .push  (push[i]),
      .entry ({bus.req_tag[i], bus.req_data[i]}),
      .pop   (pop[i]),
      .head  (head[i]),
      .empty (empty[i]),
      .full  (full[i])
    );
  end

  // First non-empty FIFO at or after the round-robin pointer wins.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr_q;
    cand   = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && !empty[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    cdb_d    = CDB_IDLE;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (!bus.flush && found) begin
      cdb_d.tag  = head[winner][ENTRY_W-1 -: TAG_W_L];
      cdb_d.data = head[winner][DATA_W-1:0];
      grant_d    = winner;
      rr_ptr_d   = (winner == LAST_IDX) ? '0 : winner + IDX_W'(1);
    end
    cdb_valid_d = (cdb_d.tag != INVALID);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_q       <= CDB_IDLE;
      cdb_valid_q <= 1'b0;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
    end else begin
      cdb_q       <= cdb_d;
      cdb_valid_q <= cdb_valid_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.cdb_out   = cdb_q;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.grant_idx = grant_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized
// traffic compared against a queue-based model of the scheduling rules.
module tb_cdb_arbiter;
  import cpu_types::*;

  localparam int NUM_REQ = CDB_NUM_REQ;
  localparam int DEPTH   = 2;
  localparam int DATA_W  = CDB_DATA_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  cdb_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DEPTH   (DEPTH),
    .DATA_W  (DATA_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one queue per producer plus a rotating priority start.
  cdb_t mq [NUM_REQ][$];
  int   m_rr;
  cdb_t exp_cdb;
  int   exp_grant;
  bit   accepted [NUM_REQ];
  int   tag_ctr = 0;

  function automatic void model_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      mq[i].delete();
      accepted[i] = 1'b0;
    end
    m_rr      = 0;
    exp_cdb   = CDB_IDLE;
    exp_grant = 0;
  endfunction

  function automatic logic [NUM_REQ-1:0] model_ready();
    logic [NUM_REQ-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REQ; i++)
      r[i] = !bus.flush && (mq[i].size() < DEPTH);
    return r;
  endfunction

  // Applies one clock edge worth of spec rules to the model using current inputs.
  function automatic void model_edge();
    logic [NUM_REQ-1:0] rdy;
    bit   do_push [NUM_REQ];
    int   win;
    cdb_t e;
    rdy = model_ready();
    win = -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      accepted[i] = bus.req_valid[i] && rdy[i];
      do_push[i]  = accepted[i] && (bus.req_tag[i] != INVALID);
    end
    if (bus.flush) begin
      for (int i = 0; i < NUM_REQ; i++) mq[i].delete();
      exp_cdb = CDB_IDLE;
      return;
    end
    for (int k = 0; k < NUM_REQ; k++)
      if (win < 0 && mq[(m_rr + k) % NUM_REQ].size() != 0) win = (m_rr + k) % NUM_REQ;
    if (win >= 0) begin
      exp_cdb   = mq[win].pop_front();
      exp_grant = win;
      m_rr      = (win + 1) % NUM_REQ;
    end else begin
      exp_cdb = CDB_IDLE;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (do_push[i]) begin
        e.tag  = bus.req_tag[i];
        e.data = bus.req_data[i];
        mq[i].push_back(e);
      end
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.flush     = 1'b0;
    bus.req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_tag[i]  = INVALID;
      bus.req_data[i] = '0;
    end
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
  endtask

  function automatic RS_tag_type next_tag();
    tag_ctr++;
    return RS_tag_type'((tag_ctr % 31) + 1);
  endfunction

  task automatic test_reset();
    n_tests++;
    if (bus.cdb_out !== CDB_IDLE) begin
      $display("FAIL reset_cdb: got %h expected %h", bus.cdb_out, CDB_IDLE); n_fail++;
    end
    n_tests++;
    if (bus.cdb_valid !== 1'b0) begin
      $display("FAIL reset_valid: got %b expected 0", bus.cdb_valid); n_fail++;
    end
    n_tests++;
    if (bus.grant_idx !== 2'd0) begin
      $display("FAIL reset_grant: got %0d expected 0", bus.grant_idx); n_fail++;
    end
    n_tests++;
    if (bus.req_ready !== 4'hF) begin
      $display("FAIL reset_ready: got %b expected 1111", bus.req_ready); n_fail++;
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    cdb_t want;
    want.tag  = RS_tag_type'(3);
    want.data = 32'h0000_00AA;
    do_reset();
    bus.req_valid[CDB_LOAD1] = 1'b1;
    bus.req_tag[CDB_LOAD1]   = want.tag;
    bus.req_data[CDB_LOAD1]  = want.data;
    tick();
    drive_idle();
    n_tests++;
    if (bus.cdb_valid !== 1'b0) begin
      $display("FAIL single_latency: got valid %b expected 0", bus.cdb_valid); n_fail++;
    end
    tick();
    n_tests++;
    if (bus.cdb_out !== want || bus.cdb_valid !== 1'b1 || bus.grant_idx !== 2'd0) begin
      $display("FAIL single_out: got %h/%b/%0d expected %h/1/0", bus.cdb_out, bus.cdb_valid, bus.grant_idx, want); n_fail++;
    end
    tick();
    n_tests++;
    if (bus.cdb_valid !== 1'b0 || bus.cdb_out.tag !== INVALID) begin
      $display("FAIL single_idle: got tag %0d valid %b expected 0/0", bus.cdb_out.tag, bus.cdb_valid); n_fail++;
    end
  endtask

  task automatic test_all_four();
    do_reset();
    bus.req_valid = 4'hF;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_tag[i]  = RS_tag_type'(i + 1);
      bus.req_data[i] = 32'h100 + i;
    end
    tick();
    drive_idle();
    for (int c = 0; c < NUM_REQ; c++) begin
      tick();
      n_tests++;
      if (bus.cdb_out.tag !== RS_tag_type'(c + 1) || bus.grant_idx !== 2'(c) || bus.cdb_valid !== 1'b1) begin
        $display("FAIL all_four_seq%0d: got tag %0d grant %0d valid %b expected %0d/%0d/1", c, bus.cdb_out.tag, bus.grant_idx, bus.cdb_valid, c + 1, c); n_fail++;
      end
    end
    bus.req_valid = 4'hF;
    for (int i = 0; i < NUM_REQ; i++) bus.req_tag[i] = RS_tag_type'(i + 5);
    tick();
    drive_idle();
    tick();
    n_tests++;
    if (bus.grant_idx !== 2'd0 || bus.cdb_out.tag !== RS_tag_type'(5)) begin
      $display("FAIL all_four_rr_wrap: got grant %0d tag %0d expected 0/5", bus.grant_idx, bus.cdb_out.tag); n_fail++;
    end
  endtask

  task automatic test_backpressure();
    int a_idx;
    bit dropped;
    bit ok;
    int alu_seen[$];
    logic [NUM_REQ-1:0] exp_r;
    do_reset();
    a_idx   = 0;
    dropped = 1'b0;
    bus.req_valid[CDB_LOAD1] = 1'b1;
    bus.req_tag[CDB_LOAD1]   = next_tag();
    bus.req_data[CDB_LOAD1]  = $urandom;
    bus.req_valid[CDB_ALU1]  = 1'b1;
    bus.req_tag[CDB_ALU1]    = RS_tag_type'(20);
    bus.req_data[CDB_ALU1]   = $urandom;
    for (int c = 0; c < 16; c++) begin
      #1;
      exp_r = model_ready();
      n_tests++;
      if (bus.req_ready !== exp_r) begin
        $display("FAIL bp_ready c%0d: got %b expected %b", c, bus.req_ready, exp_r); n_fail++;
      end
      if (bus.req_valid[CDB_ALU1] && !bus.req_ready[CDB_ALU1]) dropped = 1'b1;
      tick();
      n_tests++;
      if (bus.cdb_out !== exp_cdb || bus.grant_idx !== 2'(exp_grant) || bus.cdb_valid !== (exp_cdb.tag != INVALID)) begin
        $display("FAIL bp_out c%0d: got %h/%0d/%b expected %h/%0d", c, bus.cdb_out, bus.grant_idx, bus.cdb_valid, exp_cdb, exp_grant); n_fail++;
      end
      if (bus.cdb_valid && bus.grant_idx == 2'(CDB_ALU1)) alu_seen.push_back(int'(bus.cdb_out.tag));
      if (accepted[CDB_LOAD1]) begin
        bus.req_tag[CDB_LOAD1]  = next_tag();
        bus.req_data[CDB_LOAD1] = $urandom;
      end
      if (accepted[CDB_ALU1]) begin
        a_idx++;
        if (a_idx < 4) begin
          bus.req_tag[CDB_ALU1]  = RS_tag_type'(20 + a_idx);
          bus.req_data[CDB_ALU1] = $urandom;
        end else begin
          bus.req_valid[CDB_ALU1] = 1'b0;
        end
      end
    end
    n_tests++;
    if (dropped !== 1'b1) begin
      $display("FAIL bp_ready_drop: got %b expected 1", dropped); n_fail++;
    end
    ok = (alu_seen.size() == 4);
    for (int k = 0; k < alu_seen.size(); k++) if (alu_seen[k] != 20 + k) ok = 1'b0;
    n_tests++;
    if (!ok) begin
      $display("FAIL bp_alu_order: got %0d entries %p expected 20,21,22,23", alu_seen.size(), alu_seen); n_fail++;
    end
  endtask

  task automatic test_fairness();
    int cnt [NUM_REQ];
    int prev, repeats, nvalid;
    do_reset();
    prev = -1; repeats = 0; nvalid = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt[i] = 0;
      bus.req_valid[i] = 1'b1;
      bus.req_tag[i]   = next_tag();
      bus.req_data[i]  = $urandom;
    end
    for (int c = 0; c <= 40; c++) begin
      tick();
      n_tests++;
      if (bus.cdb_out !== exp_cdb || bus.grant_idx !== 2'(exp_grant) || bus.cdb_valid !== (exp_cdb.tag != INVALID)) begin
        $display("FAIL fair_out c%0d: got %h/%0d/%b expected %h/%0d", c, bus.cdb_out, bus.grant_idx, bus.cdb_valid, exp_cdb, exp_grant); n_fail++;
      end
      if (c >= 1) begin
        if (bus.cdb_valid) nvalid++;
        cnt[int'(bus.grant_idx)]++;
        if (int'(bus.grant_idx) == prev) repeats++;
        prev = int'(bus.grant_idx);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accepted[i]) begin
          bus.req_tag[i]  = next_tag();
          bus.req_data[i] = $urandom;
        end
      end
    end
    drive_idle();
    for (int i = 0; i < NUM_REQ; i++) begin
      n_tests++;
      if (cnt[i] !== 10) begin
        $display("FAIL fair_count%0d: got %0d expected 10", i, cnt[i]); n_fail++;
      end
    end
    n_tests++;
    if (repeats !== 0 || nvalid !== 40) begin
      $display("FAIL fair_pattern: got repeats %0d valid %0d expected 0/40", repeats, nvalid); n_fail++;
    end
  endtask

  task automatic test_flush();
    int nvalid;
    do_reset();
    bus.req_valid = 4'hF;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_tag[i]  = RS_tag_type'(11 + i);
      bus.req_data[i] = $urandom;
    end
    tick();
    drive_idle();
    bus.req_valid[CDB_LOAD1] = 1'b1; bus.req_tag[CDB_LOAD1] = RS_tag_type'(15);
    bus.req_valid[CDB_LOAD2] = 1'b1; bus.req_tag[CDB_LOAD2] = RS_tag_type'(16);
    tick();
    drive_idle();
    bus.flush = 1'b1;
    #1;
    n_tests++;
    if (bus.req_ready !== 4'h0) begin
      $display("FAIL flush_ready_low: got %b expected 0000", bus.req_ready); n_fail++;
    end
    n_tests++;
    if (bus.cdb_out.tag !== RS_tag_type'(11) || bus.cdb_valid !== 1'b1) begin
      $display("FAIL flush_inflight: got tag %0d valid %b expected 11/1", bus.cdb_out.tag, bus.cdb_valid); n_fail++;
    end
    tick();
    bus.flush = 1'b0;
    n_tests++;
    if (bus.cdb_valid !== 1'b0 || bus.cdb_out !== CDB_IDLE) begin
      $display("FAIL flush_idle: got %h valid %b expected idle", bus.cdb_out, bus.cdb_valid); n_fail++;
    end
    #1;
    n_tests++;
    if (bus.req_ready !== 4'hF) begin
      $display("FAIL flush_ready_high: got %b expected 1111", bus.req_ready); n_fail++;
    end
    nvalid = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.cdb_valid !== 1'b0) nvalid++;
    end
    n_tests++;
    if (nvalid !== 0) begin
      $display("FAIL flush_no_stale: got %0d broadcasts expected 0", nvalid); n_fail++;
    end
    bus.req_valid = 4'hF;
    for (int i = 0; i < NUM_REQ; i++) bus.req_tag[i] = RS_tag_type'(21 + i);
    tick();
    drive_idle();
    tick();
    n_tests++;
    if (bus.grant_idx !== 2'd1 || bus.cdb_out.tag !== RS_tag_type'(22)) begin
      $display("FAIL flush_rr_hold: got grant %0d tag %0d expected 1/22", bus.grant_idx, bus.cdb_out.tag); n_fail++;
    end
  endtask

  task automatic test_invalid_drop();
    int nvalid;
    do_reset();
    nvalid = 0;
    bus.req_valid = 4'hF;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_tag[i]  = INVALID;
      bus.req_data[i] = $urandom;
    end
    for (int c = 0; c < 4; c++) begin
      #1;
      n_tests++;
      if (bus.req_ready !== 4'hF) begin
        $display("FAIL invalid_ready c%0d: got %b expected 1111", c, bus.req_ready); n_fail++;
      end
      tick();
      if (bus.cdb_valid !== 1'b0) nvalid++;
    end
    drive_idle();
    tick();
    if (bus.cdb_valid !== 1'b0) nvalid++;
    n_tests++;
    if (nvalid !== 0) begin
      $display("FAIL invalid_dropped: got %0d broadcasts expected 0", nvalid); n_fail++;
    end
  endtask

  task automatic test_async_reset();
    int nvalid;
    do_reset();
    bus.req_valid = 4'hF;
    for (int i = 0; i < NUM_REQ; i++) bus.req_tag[i] = RS_tag_type'(i + 1);
    tick();
    for (int i = 0; i < NUM_REQ; i++) bus.req_tag[i] = RS_tag_type'(i + 5);
    tick();
    drive_idle();
    tick();
    n_tests++;
    if (bus.req_ready !== 4'b0011 || bus.grant_idx !== 2'd1) begin
      $display("FAIL areset_preload: got ready %b grant %0d expected 0011/1", bus.req_ready, bus.grant_idx); n_fail++;
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.cdb_out !== CDB_IDLE || bus.cdb_valid !== 1'b0 || bus.grant_idx !== 2'd0) begin
      $display("FAIL areset_outputs: got %h/%b/%0d expected idle/0/0", bus.cdb_out, bus.cdb_valid, bus.grant_idx); n_fail++;
    end
    n_tests++;
    if (bus.req_ready !== 4'hF) begin
      $display("FAIL areset_empty: got ready %b expected 1111", bus.req_ready); n_fail++;
    end
    rst = 1'b0;
    model_reset();
    nvalid = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.cdb_valid !== 1'b0) nvalid++;
    end
    n_tests++;
    if (nvalid !== 0) begin
      $display("FAIL areset_lost: got %0d broadcasts expected 0", nvalid); n_fail++;
    end
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] exp_r;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!bus.req_valid[i] || accepted[i]) begin
          bus.req_valid[i] = ($urandom_range(0, 2) != 0);
          bus.req_tag[i]   = RS_tag_type'($urandom_range(0, 31));
          bus.req_data[i]  = $urandom;
        end
      end
      bus.flush = ($urandom_range(0, 19) == 0);
      #1;
      exp_r = model_ready();
      n_tests++;
      if (bus.req_ready !== exp_r) begin
        $display("FAIL rand_ready c%0d: got %b expected %b", c, bus.req_ready, exp_r); n_fail++;
      end
      tick();
      n_tests++;
      if (bus.cdb_out !== exp_cdb || bus.grant_idx !== 2'(exp_grant) || bus.cdb_valid !== (exp_cdb.tag != INVALID)) begin
        $display("FAIL rand_out c%0d: got %h/%0d/%b expected %h/%0d", c, bus.cdb_out, bus.grant_idx, bus.cdb_valid, exp_cdb, exp_grant); n_fail++;
      end
    end
    drive_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    drive_idle();
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_fairness();
    test_flush();
    test_invalid_drop();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
